// File: rtl/fnn_pkg.sv
// fnn_pkg: shared types and constants for the fully connected network neurons.
// Provides the neuron FSM state type, the default fixed-point format (Q4.12)
// and a helper computing the overflow-free accumulator width.
package fnn_pkg;

  typedef enum logic [1:0] {
    ACCUM  = 2'd0,
    DRAIN  = 2'd1,
    OUTPUT = 2'd2
  } state_e;

  localparam int DATA_W    = 16;
  localparam int FRAC_BITS = 12;

  // Full-precision products plus enough headroom for num_w of them.
  function automatic int acc_width(input int data_w, input int num_w);
    return 2 * data_w + $clog2(num_w);
  endfunction

endpackage

// File: rtl/sat_shift.sv
// sat_shift: arithmetic right shift by fracBits (truncating) followed by
// saturation into a signed dataWidth result. Purely combinational.
// Ports: sum_i (inW-bit two's complement sum), res_o (saturated dataWidth result).
module sat_shift
  import fnn_pkg::*;
#(
  parameter int inW       = acc_width(DATA_W, 30) + 1,
  parameter int dataWidth = DATA_W,
  parameter int fracBits  = FRAC_BITS
) (
  input  logic [inW-1:0]       sum_i,
  output logic [dataWidth-1:0] res_o
);

  logic signed [inW-1:0]       shr;
  logic [inW-dataWidth:0]      top;

  assign shr = $signed(sum_i) >>> fracBits;
  // The result fits only if every bit above the output sign bit copies it.
  assign top = shr[inW-1:dataWidth-1];

  always_comb begin
    res_o = shr[dataWidth-1:0];
    if (!((top == '0) || (top == '1))) begin
      res_o = shr[inW-1] ? {1'b1, {(dataWidth-1){1'b0}}}
                         : {1'b0, {(dataWidth-1){1'b1}}};
    end
  end

endmodule

// File: rtl/neuron_mac.sv
// neuron_mac: single-neuron multiply-accumulate engine. Streams numWeight
// activations, reads one weight per accepted activation from an external
// registered-read memory, accumulates x*w, adds bias, shifts/saturates and
// optionally applies ReLU (macro NEURON_RELU_EN; linear output when undefined).
// Ports: clk/rst_n (sync active-low); in_data/in_valid/in_ready activation
// stream; bias; w_ren/w_radd/w_data weight memory; out_data/out_valid result.
module neuron_mac
  import fnn_pkg::*;
#(
  parameter int numWeight    = 30,
  parameter int addressWidth = $clog2(numWeight),
  parameter int dataWidth    = DATA_W,
  parameter int fracBits     = FRAC_BITS
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [dataWidth-1:0]    in_data,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [dataWidth-1:0]    bias,
  output logic                    w_ren,
  output logic [addressWidth-1:0] w_radd,
  input  logic [dataWidth-1:0]    w_data,
  output logic [dataWidth-1:0]    out_data,
  output logic                    out_valid
);

  localparam int ACC_W  = acc_width(dataWidth, numWeight);
  localparam int PROD_W = 2 * dataWidth;
  localparam int SUM_W  = ACC_W + 1;
  localparam logic [addressWidth-1:0] LAST = addressWidth'(numWeight - 1);

  state_e                    state_q, state_d;
  logic [addressWidth-1:0]   count_q, count_d;
  logic                      rdy_q;
  logic                      accept;
  logic [dataWidth-1:0]      x_q;
  logic                      v1_q, v2_q;   // x_q / prod_q hold a live operand
  logic signed [PROD_W-1:0]  prod_d, prod_q;
  logic [ACC_W-1:0]          acc_q, acc_d;
  logic [SUM_W-1:0]          sum;
  logic [dataWidth-1:0]      sat_res, res_d;
  logic [dataWidth-1:0]      out_data_q;
  logic                      out_valid_q;

  assign accept   = in_valid && rdy_q;
  assign in_ready = rdy_q;
  assign w_ren    = accept;
  assign w_radd   = count_q;

  // Weight returns one cycle after the read, lining up with x_q.
  assign prod_d = $signed({{dataWidth{x_q[dataWidth-1]}}, x_q}) *
                  $signed({{dataWidth{w_data[dataWidth-1]}}, w_data});

  always_comb begin
    acc_d = acc_q;
    if (state_q == OUTPUT) begin
      acc_d = '0;
    end else if (v2_q) begin
      acc_d = acc_q + {{(ACC_W-PROD_W){prod_q[PROD_W-1]}}, prod_q};
    end
  end

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    case (state_q)
      ACCUM: begin
        if (accept) begin
          if (count_q == LAST) begin
            count_d = '0;
            state_d = DRAIN;
          end else begin
            count_d = count_q + addressWidth'(1);
          end
        end
      end
      // Once x_q is empty the last product sits in prod_q and is being
      // folded into acc this cycle, so acc is final in the next one.
      DRAIN:   if (!v1_q) state_d = OUTPUT;
      OUTPUT:  state_d = ACCUM;
      default: state_d = ACCUM;
    endcase
  end

  // Bias is aligned to the accumulator's binary point before adding.
  assign sum = {acc_q[ACC_W-1], acc_q} +
               {{(SUM_W-fracBits-dataWidth){bias[dataWidth-1]}}, bias, {fracBits{1'b0}}};

  sat_shift #(
    .inW       (SUM_W),
    .dataWidth (dataWidth),
    .fracBits  (fracBits)
  ) u_sat_shift (
    .sum_i (sum),
    .res_o (sat_res)
  );

`ifdef NEURON_RELU_EN
  assign res_d = sat_res[dataWidth-1] ? '0 : sat_res;
`else
  assign res_d = sat_res;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ACCUM;
      count_q     <= '0;
      rdy_q       <= 1'b0;
      x_q         <= '0;
      v1_q        <= 1'b0;
      v2_q        <= 1'b0;
      prod_q      <= '0;
      acc_q       <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      rdy_q       <= (state_d == ACCUM);
      v1_q        <= accept;
      v2_q        <= v1_q;
      if (accept) x_q <= in_data;
      prod_q      <= prod_d;
      acc_q       <= acc_d;
      out_valid_q <= (state_q == OUTPUT);
      if (state_q == OUTPUT) out_data_q <= res_d;
    end
  end

  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;

endmodule

// File: tb/tb_neuron_mac.sv
// tb_neuron_mac: randomized self-checking bench for neuron_mac. Two instances
// (numWeight=4 and 30) share stimulus through a select; a behavioural model
// computes each neuron result from the spec arithmetic on whole vectors.
module tb_neuron_mac;

  logic        clk;
  logic        rst_n;
  logic        sel;          // 0: 4-input instance, 1: 30-input instance
  logic [15:0] in_data;
  logic        in_valid;
  logic [15:0] bias;

  logic        rdy4, ren4, ov4;
  logic [1:0]  radd4;
  logic [15:0] wd4, od4;
  logic        rdy30, ren30, ov30;
  logic [4:0]  radd30;
  logic [15:0] wd30, od30;

  logic        in_ready, w_ren, out_valid;
  logic [31:0] w_radd;
  logic [15:0] out_data;

  logic [15:0] w  [0:29];
  logic [15:0] xs [0:29];

  int          n_chk = 0;
  int          n_pass = 0;
  int          cyc = 0;
  int          rdy_from = 1 << 30;
  logic [15:0] exp_q[$];
  int          t_q[$];
  logic [15:0] exp_hold = 16'h0;
  logic [15:0] last_out = 16'h0;
  logic [15:0] mon_e;
  int          mon_t;

  neuron_mac #(.numWeight(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid && !sel),
    .in_ready(rdy4), .bias(bias), .w_ren(ren4), .w_radd(radd4), .w_data(wd4),
    .out_data(od4), .out_valid(ov4)
  );

  neuron_mac #(.numWeight(30)) dut30 (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid && sel),
    .in_ready(rdy30), .bias(bias), .w_ren(ren30), .w_radd(radd30), .w_data(wd30),
    .out_data(od30), .out_valid(ov30)
  );

  assign in_ready  = sel ? rdy30 : rdy4;
  assign w_ren     = sel ? ren30 : ren4;
  assign w_radd    = sel ? 32'(radd30) : 32'(radd4);
  assign out_data  = sel ? od30 : od4;
  assign out_valid = sel ? ov30 : ov4;

  // Registered-read weight memories
  always @(posedge clk) begin
    if (ren4)  wd4  <= w[radd4];
    if (ren30) wd30 <= w[radd30];
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
  endtask

  // Reference: dot product, bias in Q format, floor shift, clamp, optional ReLU.
  function automatic logic [15:0] model(input longint s, input logic [15:0] b);
    longint tot;
    longint r;
    tot = s + longint'($signed(b)) * 4096;
    r = tot >>> 12;
    if (r > 32767) r = 32767;
    else if (r < -32768) r = -32768;
`ifdef NEURON_RELU_EN
    if (r < 0) r = 0;
`endif
    return r[15:0];
  endfunction

  function automatic logic [15:0] rnd(input bit big);
    int v;
    if (big) v = int'($urandom);
    else v = int'($urandom_range(8191, 0)) - 4096;
    return 16'(v);
  endfunction

  // Result monitor: every out_valid must match the oldest expected result.
  always @(negedge clk) begin
    #2;
    if (rst_n === 1'b1) begin
      if (out_valid === 1'b1) begin
        if (exp_q.size() == 0) begin
          check_val("spurious_out_valid", 32'(out_valid), 32'd0);
        end else begin
          mon_e = exp_q.pop_front();
          mon_t = t_q.pop_front();
          check_val("out_data", 32'(out_data), 32'(mon_e));
          check_val("latency", cyc - mon_t, 4);
          check_val("in_ready_at_out", 32'(in_ready), 32'd1);
          exp_hold = mon_e;
          last_out = out_data;
        end
      end else begin
        check_val("out_hold", 32'(out_data), 32'(exp_hold));
      end
    end
  end

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    in_valid = 1'b0;
    rdy_from = 1 << 30;
    repeat (2) @(negedge clk);
    #1;
    check_val("rst_in_ready", 32'(in_ready), 32'd0);
    check_val("rst_w_ren", 32'(w_ren), 32'd0);
    check_val("rst_w_radd", w_radd, 32'd0);
    check_val("rst_out_data", 32'(out_data), 32'd0);
    check_val("rst_out_valid", 32'(out_valid), 32'd0);
    exp_hold = 16'h0;
    @(negedge clk);
    rst_n = 1'b1;
    rdy_from = cyc + 1;
  endtask

  // Present xs[0..take-1] with random gaps; the result is expected only
  // when the whole n-element vector is accepted.
  task automatic run_vec(input int n, input int take, input int gap_max);
    int     k;
    int     g;
    int     budget;
    longint s;
    logic   acc_now;
    logic   exp_rdy;
    k = 0; s = 0; budget = 0;
    g = int'($urandom_range(gap_max, 0));
    while (k < take && budget < 400) begin
      @(negedge clk);
      budget++;
      if (g > 0) begin
        in_valid = 1'b0;
        g--;
      end else begin
        in_valid = 1'b1;
        in_data = xs[k];
      end
      #1;
      exp_rdy = (cyc >= rdy_from);
      acc_now = in_valid && exp_rdy;
      check_val("in_ready", 32'(in_ready), 32'(exp_rdy));
      check_val("w_ren", 32'(w_ren), 32'(acc_now));
      if (acc_now) begin
        check_val("w_radd", w_radd, k);
        s += longint'($signed(xs[k])) * longint'($signed(w[k]));
        if (k == n - 1) begin
          exp_q.push_back(model(s, bias));
          t_q.push_back(cyc);
          rdy_from = cyc + 4;
        end
        k++;
        g = int'($urandom_range(gap_max, 0));
      end
    end
    if (k < take) check_val("drive_timeout", k, take);
  endtask

  task automatic wait_idle();
    int budget;
    budget = 0;
    while (exp_q.size() != 0 && budget < 50) begin
      @(negedge clk);
      in_valid = 1'b0;
      budget++;
      #1;
      check_val("in_ready_idle", 32'(in_ready), 32'(cyc >= rdy_from));
      check_val("w_ren_idle", 32'(w_ren), 32'd0);
    end
    if (exp_q.size() != 0) begin
      check_val("result_timeout", exp_q.size(), 0);
      exp_q.delete();
      t_q.delete();
    end
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; sel = 1'b0; in_valid = 1'b0; in_data = 16'h0; bias = 16'h0;
    for (int i = 0; i < 30; i++) begin w[i] = 16'h1000; xs[i] = 16'h0400; end
    do_reset();

    // 4 x 0.25 * 1.0 + 0.5
    bias = 16'h0800;
    run_vec(4, 4, 0);
    wait_idle();
    check_val("tp_basic", 32'(last_out), 32'h1800);

    // Negative result: ReLU clamps, linear passes -1.0
    for (int i = 0; i < 4; i++) xs[i] = 16'hFC00;
    bias = 16'h0000;
    run_vec(4, 4, 0);
    wait_idle();
`ifdef NEURON_RELU_EN
    check_val("tp_negative", 32'(last_out), 32'h0000);
`else
    check_val("tp_negative", 32'(last_out), 32'hF000);
`endif

    // Gapped stream gives the same answer
    for (int i = 0; i < 4; i++) xs[i] = 16'h0400;
    bias = 16'h0800;
    run_vec(4, 4, 3);
    wait_idle();
    check_val("tp_gaps", 32'(last_out), 32'h1800);

    // Abort after 2 accepts, then a clean vector
    run_vec(4, 2, 0);
    do_reset();
    run_vec(4, 4, 0);
    wait_idle();
    check_val("tp_after_abort", 32'(last_out), 32'h1800);

    // Randomized vectors, half of them followed back-to-back by a second one
    for (int it = 0; it < 24; it++) begin
      for (int i = 0; i < 4; i++) begin
        w[i]  = rnd(it % 3 == 0);
        xs[i] = rnd(it % 3 == 1);
      end
      bias = rnd(it % 4 == 1);
      run_vec(4, 4, it % 3);
      if (it % 2 == 0) begin
        for (int i = 0; i < 4; i++) xs[i] = rnd(it % 4 == 2);
        run_vec(4, 4, 0);
      end
      wait_idle();
    end

    // 30-input instance: 15.0 saturates to the positive limit
    sel = 1'b1;
    exp_hold = 16'h0;
    do_reset();
    for (int i = 0; i < 30; i++) begin w[i] = 16'h1000; xs[i] = 16'h0800; end
    bias = 16'h0000;
    run_vec(30, 30, 0);
    wait_idle();
    check_val("tp_saturate", 32'(last_out), 32'h7FFF);

    for (int it = 0; it < 6; it++) begin
      for (int i = 0; i < 30; i++) begin
        w[i]  = rnd(it % 3 == 0);
        xs[i] = rnd(it % 3 == 2);
      end
      bias = rnd(it % 2 == 1);
      run_vec(30, 30, it % 2);
      if (it % 2 == 1) begin
        for (int i = 0; i < 30; i++) xs[i] = rnd(1'b0);
        run_vec(30, 30, 0);
      end
      wait_idle();
    end

    repeat (3) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/neuron_mac.md
# neuron_mac

Single-neuron multiply-accumulate engine of the fully connected network. It consumes a serial stream of activations and, for each accepted activation, drives a registered read of its per-neuron weight memory. It multiplies the activation by the returned weight, accumulates numWeight products, adds a bias, shifts back to the data format with saturation, and applies an optional ReLU. It sits directly downstream of a per-neuron weight memory (registered read, `ren`/`radd` → `wout`) and upstream of the next layer's input stream.

## Interface

Parameters:

- numWeight, 30, inputs per neuron (equals the weight memory depth).
- addressWidth, $clog2(numWeight), weight address width.
- dataWidth, 16, signed fixed-point width of activations, weights, bias and output.
- fracBits, 12, fraction bits of the fixed-point format (Q4.12 at defaults).

Ports:

- clk  in  1  clock; single clock domain.
- rst_n  in  1  reset; synchronous, active-low.
- in_data  in  dataWidth  signed activation.
- in_valid  in  1  activation valid.
- in_ready  out  1  block can accept an activation.
- bias  in  dataWidth  signed bias in the same Q format; must be static while a neuron computation is in flight.
- w_ren  out  1  weight memory read enable.
- w_radd  out  addressWidth  weight memory read address.
- w_data  in  dataWidth  weight memory registered output; valid one cycle after `w_ren`.
- out_data  out  dataWidth  neuron result.
- out_valid  out  1  one-cycle result strobe.

## Operation

- Accept rule: an activation is accepted in a cycle where `in_valid && in_ready`.
- States: ACCUM, DRAIN, OUTPUT.
- ACCUM:
  - `in_ready`=1.
  - Each accept sets `w_ren`=1 and `w_radd`=count in the same cycle (combinational from count), registers `in_data` into `x_d`, and increments count.
  - Gaps in `in_valid` are allowed; `w_ren`=0 when nothing is accepted.
- Last accept (count == numWeight-1): count wraps to 0 and the FSM moves to DRAIN.
- DRAIN: `in_ready`=0; the FSM waits until the final product has been accumulated.
- OUTPUT:
  - Result computed as sum = acc + (sign-extended bias <<< fracBits), then res = sum >>> fracBits (arithmetic shift, truncation).
  - res is saturated to [-2^(dataWidth-1), 2^(dataWidth-1)-1].
  - ReLU is applied if configured.
  - `out_data` and `out_valid` are registered. The accumulator clears and the FSM returns to ACCUM.
- Arithmetic widths:
  - Product: 2*dataWidth signed.
  - Accumulator: accWidth = 2*dataWidth + $clog2(numWeight) signed. This width cannot overflow, so saturation is applied only at the output.
- `out_data` holds its value until the next `out_valid`.

## Timing

- Reset values: `in_ready`=0, `w_ren`=0, `w_radd`=0, `out_data`=0, `out_valid`=0.
- After reset: count=0, acc=0, state ACCUM. `in_ready` rises on the first cycle after `rst_n` goes high.
- Pipeline, with activation k accepted in cycle t:
  - Weight on `w_data` in t+1.
  - Product register captures `x_d*w_data` at the end of t+1.
  - acc updates at the end of t+2.
- Result latency: if the last activation is accepted in cycle t, `out_valid` is high in cycle t+4 for exactly one cycle.
- `in_ready` timing: falls in cycle t+1. It returns high in cycle t+4 (concurrent with `out_valid`), so the next neuron computation can start in that cycle.
- Back-to-back accepts (one per cycle) are supported. Throughput is numWeight+3 cycles per result.
- Reset mid-operation: the pipeline, count, acc and FSM clear immediately. No `out_valid` is produced for the aborted computation.

## Configuration

- `NEURON_RELU_EN` defined: negative saturated results output 0; non-negative results pass unchanged.
- `NEURON_RELU_EN` undefined: linear activation; the saturated result is output as is (used for the final layer).

## Structure

- Shared package `fnn_pkg` holds:
  - the state enum (ACCUM, DRAIN, OUTPUT);
  - localparams DATA_W=16 and FRAC_BITS=12;
  - a function computing accWidth.
- Sub-module `sat_shift`: arithmetic right shift by fracBits plus saturation from accWidth+1 bits to dataWidth. It is a combinational block reused by the other neuron variants.
- The weight memory is instantiated by the parent layer, not inside this block.

## Test plan

- numWeight=4, all weights 0x1000 (1.0), inputs 0x0400 (0.25) back-to-back, bias 0x0800 → `out_data`=0x1800, `out_valid` 4 cycles after the last accept; `w_radd` sequence 0,1,2,3.
- Defaults (numWeight=30), weights 0x1000, inputs 0x0800 (0.5), bias 0 → sum 15.0 saturates to `out_data`=0x7FFF.
- numWeight=4, weights 0x1000, inputs 0xFC00 (-0.25), bias 0 → 0x0000 with `NEURON_RELU_EN`, 0xF000 without.
- Same as the first scenario with random 0–3 cycle gaps on `in_valid` → identical result; `w_ren` high only on accept cycles.
- Assert `rst_n`=0 after 2 of 4 accepts, release, then run a full vector → no `out_valid` for the aborted run; the next result equals the clean-run value.
- Two neurons back-to-back with new inputs presented in the `out_valid` cycle → second result correct; accumulator starts from 0.
